// File: rtl/dassign3_pkg.sv
// rtl/dassign3_pkg.sv - shared types, Morse timing constants and helpers for dassign3
// Purpose: state enum, Morse unit durations (in clock cycles), timer width and
//          a helper that maps a symbol (dot/dash) to its timer load value.
// Ports:   none (package).
package dassign3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    GAP,
    CGAP,
    SPACE
  } state_t;

  localparam int DOT_LEN  = 1;
  localparam int DASH_LEN = 3;
  localparam int SYM_GAP  = 1;
  localparam int CHAR_GAP = 3;
  localparam int WORD_GAP = 7;
  localparam int MAX_SYMS = 8;

  // Wide enough to hold the longest load value (WORD_GAP-1).
  localparam int TMR_W = 3;

  // The timer counts down to zero, so a duration of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] sym_load(input logic dash);
    return dash ? TMR_W'(DASH_LEN - 1) : TMR_W'(DOT_LEN - 1);
  endfunction

endpackage

// File: rtl/morse_timer.sv
// rtl/morse_timer.sv - loadable down-counter timing Morse durations
// Purpose: counts the remaining cycles of the current Morse element.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset, clears the count
//   i_load     in   load i_load_val on this edge (wins over counting)
//   i_load_val in   TMR_W bits, duration minus one
//   o_done     out  count is zero: current cycle is the last of the element
//   o_last     out  count is one: next cycle is the last of the element
module morse_timer
  import dassign3_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_done,
  output logic             o_last
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);
  assign o_last = (r_count == TMR_W'(1));

endmodule

// File: rtl/dassign3.sv
// rtl/dassign3.sv - Morse code character transmitter driving a single LED
// Purpose: accepts one character (symbol pattern + count) at a time and plays
//          it on led_drv with standard Morse timing, 1 unit = 1 clock cycle.
// Ports:
//   char_vald     in   1  one-cycle pulse, code/length valid when high
//   charcode_data in   8  symbol pattern, MSB first, 1 = dash, 0 = dot
//   charlen_data  in   4  symbol count 0..8, 0 = word space (>8 clamps to 8)
//   char_next     out  1  registered one-cycle pulse, character finished
//   led_drv       out  1  registered LED drive, 1 = lit
//   reset         in   1  synchronous active-high reset
//   clock         in   1  rising-edge clock
module dassign3
  import dassign3_pkg::*;
(
  input  logic       char_vald,
  input  logic [7:0] charcode_data,
  input  logic [3:0] charlen_data,
  output logic       char_next,
  output logic       led_drv,
  input  logic       reset,
  input  logic       clock
);

  state_t           r_state;
  logic [7:0]       r_code;
  logic [3:0]       r_sym_left;
  logic             r_led;
  logic             r_next;

  logic [3:0]       w_len_clamp;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_done;
  logic             w_tmr_last;

  assign w_len_clamp = (charlen_data > 4'(MAX_SYMS)) ? 4'(MAX_SYMS) : charlen_data;

  // Timer reload happens on the same edge as the state change, so the
  // duration of the state being entered is selected combinationally here.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        if (char_vald) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (w_len_clamp == 4'd0) ? TMR_W'(WORD_GAP - 1)
                                             : sym_load(charcode_data[7]);
        end
      end
      ON: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (r_sym_left == 4'd1) ? TMR_W'(CHAR_GAP - 1)
                                            : TMR_W'(SYM_GAP - 1);
        end
      end
      GAP: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = sym_load(r_code[7]);
        end
      end
      default: begin
      end
    endcase
  end

  morse_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done),
    .o_last     (w_tmr_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_code     <= '0;
      r_sym_left <= '0;
      r_led      <= 1'b0;
      r_next     <= 1'b0;
    end else begin
      r_next <= 1'b0;
      case (r_state)
        IDLE: begin
          if (char_vald) begin
            r_code     <= charcode_data;
            r_sym_left <= w_len_clamp;
            if (w_len_clamp != 4'd0) begin
              r_state <= ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= SPACE;
            end
          end
        end
        ON: begin
          if (w_tmr_done) begin
            r_led <= 1'b0;
            if (r_sym_left == 4'd1) begin
              r_state <= CGAP;
            end else begin
              // Shift while entering the gap so the next symbol's MSB is
              // already in place when the gap ends and reloads the timer.
              r_state    <= GAP;
              r_code     <= {r_code[6:0], 1'b0};
              r_sym_left <= r_sym_left - 4'd1;
            end
          end
        end
        GAP: begin
          if (w_tmr_done) begin
            r_state <= ON;
            r_led   <= 1'b1;
          end
        end
        CGAP, SPACE: begin
          // Raise char_next one edge early so it lands on the final gap cycle.
          if (w_tmr_last) begin
            r_next <= 1'b1;
          end
          if (w_tmr_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign char_next = r_next;
  assign led_drv   = r_led;

endmodule

// File: tb/tb_dassign3.sv
// tb/tb_dassign3.sv - directed self-checking bench for dassign3
module tb_dassign3;

  logic       clock = 1'b0;
  logic       reset;
  logic       char_vald;
  logic [7:0] charcode_data;
  logic [3:0] charlen_data;
  logic       char_next;
  logic       led_drv;

  int n_vec  = 0;
  int n_miss = 0;

  logic [63:0] tr_led;
  logic [63:0] tr_cn;

  dassign3 dut (
    .char_vald     (char_vald),
    .charcode_data (charcode_data),
    .charlen_data  (charlen_data),
    .char_next     (char_next),
    .led_drv       (led_drv),
    .reset         (reset),
    .clock         (clock)
  );

  always #5 clock = ~clock;

  // Present one character for the next edge; returns 1 time unit after it,
  // i.e. while the first cycle after the latching edge is in progress.
  task automatic send(input logic [7:0] code, input logic [3:0] len);
    char_vald     = 1'b1;
    charcode_data = code;
    charlen_data  = len;
    @(posedge clock);
    #1;
    char_vald     = 1'b0;
    charcode_data = 8'h00;
    charlen_data  = 4'd0;
  endtask

  // Record n cycles of outputs, first cycle ends up in the highest bit.
  // A set bit i in pulse_mask pulses char_vald ('T') during cycle i.
  task automatic capture(input int n, input logic [31:0] pulse_mask);
    tr_led = '0;
    tr_cn  = '0;
    for (int i = 0; i < n; i++) begin
      tr_led = {tr_led[62:0], led_drv};
      tr_cn  = {tr_cn[62:0], char_next};
      if (pulse_mask[i]) begin
        char_vald     = 1'b1;
        charcode_data = 8'h80;
        charlen_data  = 4'd1;
      end
      @(posedge clock);
      #1;
      char_vald     = 1'b0;
      charcode_data = 8'h00;
      charlen_data  = 4'd0;
    end
  endtask

  task automatic test_reset;
    logic [63:0] exp;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (led_drv !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_led got %b want 0", led_drv);
    end
    n_vec++;
    if (char_next !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_cn got %b want 0", char_next);
    end
    // reset and char_vald on the same edge: reset wins
    char_vald     = 1'b1;
    charcode_data = 8'h80;
    charlen_data  = 4'd1;
    @(posedge clock);
    #1;
    char_vald = 1'b0;
    reset     = 1'b0;
    capture(8, 32'h0);
    exp = 64'h0;
    n_vec++;
    if (tr_led !== exp) begin
      n_miss++;
      $display("FAIL reset_prio_led got %b want %b", tr_led, exp);
    end
    n_vec++;
    if (tr_cn !== exp) begin
      n_miss++;
      $display("FAIL reset_prio_cn got %b want %b", tr_cn, exp);
    end
  endtask

  task automatic test_t;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'b1000_0000, 4'd1);
    capture(7, 32'h0);
    exp_led = 64'(7'b111_000_0);
    exp_cn  = 64'(7'b000_001_0);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL T_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL T_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_m;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'b1100_0000, 4'd2);
    capture(11, 32'h0);
    exp_led = 64'(11'b111_0_111_000_0);
    exp_cn  = 64'(11'b000_0_000_001_0);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL M_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL M_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'b0100_0000, 4'd2);
    capture(8, 32'h0);
    exp_led = 64'(8'b1_0_111_000);
    exp_cn  = 64'(8'b0_0_000_001);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL A_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL A_cn got %b want %b", tr_cn, exp_cn);
    end
    // cycle right after char_next: idle, and the next character is accepted
    n_vec++;
    if ({led_drv, char_next} !== 2'b00) begin
      n_miss++;
      $display("FAIL A_idle got %b want 00", {led_drv, char_next});
    end
    send(8'b0111_1000, 4'd5);
    capture(21, 32'h0);
    exp_led = 64'(21'b1_0_111_0_111_0_111_0_111_000_0);
    exp_cn  = 64'(21'b0_0_000_0_000_0_000_0_000_001_0);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL one_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL one_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_space;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'hFF, 4'd0);
    capture(8, 32'h0);
    exp_led = 64'h0;
    exp_cn  = 64'(8'b0000_0010);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL space_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL space_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_ignore_vald;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'b0100_0000, 4'd2);
    // pulses during the dash and during the character gap
    capture(10, 32'h0000_0044);
    exp_led = 64'(10'b1_0_111_000_00);
    exp_cn  = 64'(10'b0_0_000_001_00);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL ignore_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL ignore_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_clamp;
    logic [63:0] exp_led;
    logic [63:0] exp_cn;
    send(8'h00, 4'd12);
    capture(19, 32'h0);
    exp_led = 64'(19'b101010101010101_000_0);
    exp_cn  = 64'(19'b000000000000000_001_0);
    n_vec++;
    if (tr_led !== exp_led) begin
      n_miss++;
      $display("FAIL clamp_led got %b want %b", tr_led, exp_led);
    end
    n_vec++;
    if (tr_cn !== exp_cn) begin
      n_miss++;
      $display("FAIL clamp_cn got %b want %b", tr_cn, exp_cn);
    end
  endtask

  task automatic test_reset_mid_dash;
    logic [63:0] exp;
    send(8'b1100_0000, 4'd2);
    capture(2, 32'h0);
    exp = 64'(2'b11);
    n_vec++;
    if (tr_led !== exp) begin
      n_miss++;
      $display("FAIL mid_dash_led got %b want %b", tr_led, exp);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    capture(10, 32'h0);
    exp = 64'h0;
    n_vec++;
    if (tr_led !== exp) begin
      n_miss++;
      $display("FAIL abort_led got %b want %b", tr_led, exp);
    end
    n_vec++;
    if (tr_cn !== exp) begin
      n_miss++;
      $display("FAIL abort_cn got %b want %b", tr_cn, exp);
    end
    test_t();
  endtask

  initial begin
    reset         = 1'b1;
    char_vald     = 1'b0;
    charcode_data = 8'h00;
    charlen_data  = 4'd0;
    test_reset();
    test_t();
    test_m();
    test_back_to_back();
    test_space();
    test_ignore_vald();
    test_clamp();
    test_reset_mid_dash();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dassign3.md
DASSIGN3 -- requirements
Module: dassign3

Interface
REQ-001 SHALL provide ports in this order: char_vald, charcode_data, charlen_data, char_next, led_drv, reset, clock.
REQ-002 SHALL: clock  input  1  single clock; all logic rising-edge; 1 Morse time unit = 1 clock cycle.
REQ-003 SHALL: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: char_vald  input  1  one-cycle pulse; charcode_data and charlen_data are valid when it is sampled high.
REQ-005 SHALL: charcode_data  input  8  symbol pattern, MSB sent first; 1 = dash, 0 = dot.
REQ-006 SHALL: charlen_data  input  4  symbol count, 0..8; 0 = word space.
REQ-007 SHALL: char_next  output  1  registered one-cycle pulse; current character is finished and the next one may be presented.
REQ-008 SHALL: led_drv  output  1  registered LED drive; 1 = lit.

Function
REQ-009 SHALL have states IDLE, ON, GAP, CGAP and SPACE.
REQ-010 SHALL, in IDLE, latch code and length on a clock edge with char_vald=1; char_vald is ignored in every other state.
REQ-011 SHALL clamp latched length values above 8 to 8.
REQ-012 SHALL, when latched length > 0, enter ON with led_drv=1 from the latching edge (no idle cycle).
REQ-013 SHALL hold led_drv=1 for 1 cycle for a dot and 3 cycles for a dash, using the current MSB of the shifted code.
REQ-014 SHALL, after each non-final symbol, drive led_drv=0 for exactly 1 cycle (GAP), then shift the code left by 1 and start the next symbol.
REQ-015 SHALL, after the final symbol, drive led_drv=0 for 3 cycles (CGAP) and assert char_next during the 3rd of them, then return to IDLE.
REQ-016 SHALL, when latched length = 0, hold led_drv=0 for 7 cycles counted from the latching edge (SPACE) and assert char_next during the 7th, then return to IDLE.
REQ-017 SHALL keep char_next high for exactly one cycle per accepted character and low at all other times, including IDLE.
REQ-018 SHALL accept a new char_vald in IDLE on the cycle immediately after the char_next cycle.
REQ-019 SHALL hold led_drv=0 in IDLE and in all gap states.
REQ-020 SHALL never assert char_next without a preceding accepted char_vald.

Reset
REQ-021 SHALL, on reset=1 at a clock edge: state=IDLE, led_drv=0, char_next=0, counters and latched code/length cleared.
REQ-022 SHALL give reset priority over char_vald on the same edge.
REQ-023 SHALL, on reset during any transmission, abort it; no char_next is produced for the aborted character.

Structure
REQ-024 SHALL place the following in shared package dassign3_pkg: state enum, DOT_LEN=1, DASH_LEN=3, SYM_GAP=1, CHAR_GAP=3, WORD_GAP=7, MAX_SYMS=8.
REQ-025 SHALL implement duration timing in one sub-module, morse_timer: loadable down-counter with a done flag; the FSM, code shift register and symbol counter stay in dassign3.

Verification
REQ-026 SHALL cover 'T' (code 10000000, len 1) -> led_drv high 3 cycles, low 3 cycles, char_next in the 3rd low cycle.
REQ-027 SHALL cover 'M' (code 11000000, len 2) -> led pattern 1,1,1,0,1,1,1 then 3 low cycles; char_next on the last of those.
REQ-028 SHALL cover 'A' (code 01000000, len 2) then '1' (code 01111000, len 5) back-to-back -> decoded sequences ".-" and ".----", one char_next each.
REQ-029 SHALL cover space (len 0) -> led_drv low for 7 cycles, char_next in the 7th cycle, no LED activity.
REQ-030 SHALL cover reset asserted mid-dash of 'M' -> led_drv=0 and IDLE next cycle, no char_next; a following 'T' transmits correctly.
REQ-031 SHALL cover char_vald pulsed during an active 'A' transmission -> pulse ignored; 'A' completes unchanged.
